// File: rtl/dvp_axis_pack_if.sv
`default_nettype none
// ============================================================================
// Module   : dvp_axis_pack_if
// Function : DVP byte-bus input and AXI4-Stream pixel output bundle for dvp_axis_pack
// Revision : 1.0  initial release
// ============================================================================
interface dvp_axis_pack_if #(
   parameter int BYTE_W        = 8,
   parameter int BYTES_PER_PIX = 2,
   parameter int LINE_CNT_W    = 12
);
   logic                              vsync_i;
   logic                              hsync_i;
   logic [BYTE_W-1:0]                 data_i;
   logic [BYTE_W*BYTES_PER_PIX-1:0]   tdata_o;
   logic [BYTES_PER_PIX-1:0]          tkeep_o;
   logic                              tuser_o;
   logic                              tlast_o;
   logic                              tvalid_o;
   logic                              tready_i;
   logic                              overflow_o;
   logic                              err_o;
   logic [LINE_CNT_W-1:0]             line_cnt_o;

   // master = the bridge, slave = sensor pins plus stream sink
   modport master (
      input  vsync_i, hsync_i, data_i, tready_i,
      output tdata_o, tkeep_o, tuser_o, tlast_o, tvalid_o, overflow_o, err_o, line_cnt_o
   );

   modport slave (
      output vsync_i, hsync_i, data_i, tready_i,
      input  tdata_o, tkeep_o, tuser_o, tlast_o, tvalid_o, overflow_o, err_o, line_cnt_o
   );
endinterface
`default_nettype wire

// File: rtl/dvp_axis_pack.sv
`default_nettype none
// ============================================================================
// Module   : dvp_axis_pack
// Function : DVP camera bus to AXI4-Stream bridge, packs bytes into pixel beats, FIFO-buffered
// Revision : 1.0  initial release
// ============================================================================
module dvp_axis_pack #(
   parameter int BYTE_W        = 8,
   parameter int BYTES_PER_PIX = 2,
   parameter int FIFO_DEPTH    = 16,
   parameter int LINE_CNT_W    = 12
) (
   input  wire logic        pclk_i,
   input  wire logic        rst_i,
   dvp_axis_pack_if.master  bus
);
   localparam int                    c_PIX_W    = BYTE_W * BYTES_PER_PIX;
   localparam int                    c_ENT_W    = c_PIX_W + 2;
   localparam int                    c_PTR_W    = $clog2(FIFO_DEPTH);
   localparam int                    c_CNT_W    = c_PTR_W + 1;
   localparam logic [1:0]            c_LAST_IDX = 2'(BYTES_PER_PIX - 1);
   localparam logic [c_CNT_W-1:0]    c_DEPTH    = c_CNT_W'(FIFO_DEPTH);
   localparam logic [LINE_CNT_W-1:0] c_LINE_MAX = '1;

   logic                     r_vsync_d;
   logic                     r_hsync_d;
   logic [BYTE_W-1:0]        r_data_d;
   logic [1:0]               r_idx;
   logic [c_PIX_W-1:0]       r_pix;
   logic                     r_sof_armed;
   logic                     r_push;
   logic [c_ENT_W-1:0]       r_push_ent;
   logic [c_ENT_W-1:0]       r_mem [FIFO_DEPTH];
   logic [c_PTR_W-1:0]       r_wr_ptr;
   logic [c_PTR_W-1:0]       r_rd_ptr;
   logic [c_CNT_W-1:0]       r_count;
   logic                     r_overflow;
   logic                     r_err;
   logic [LINE_CNT_W-1:0]    r_line_cnt;

   logic                     w_active;
   logic                     w_line_end;
   logic                     w_frame_start;
   logic                     w_pix_done;
   logic [c_PIX_W+BYTE_W-1:0] w_pix_full;
   logic [c_PIX_W-1:0]       w_pix_next;
   logic                     w_valid;
   logic                     w_pop;
   logic                     w_full;
   logic                     w_wr_en;
   logic [c_ENT_W-1:0]       w_head;

   // Bytes only count while the line is active outside vertical blanking; vsync rising mid-line closes the line.
   assign w_active      = r_hsync_d & ~r_vsync_d;
   assign w_line_end    = w_active & (~bus.hsync_i | bus.vsync_i);
   assign w_frame_start = r_vsync_d & ~bus.vsync_i;
   assign w_pix_done    = w_active & (r_idx == c_LAST_IDX);
   assign w_pix_full    = {r_pix, r_data_d};
   assign w_pix_next    = w_pix_full[c_PIX_W-1:0];

   assign w_valid = (r_count != '0);
   assign w_pop   = w_valid & bus.tready_i;
   assign w_full  = (r_count == c_DEPTH);
   assign w_wr_en = r_push & (~w_full | w_pop);
   assign w_head  = r_mem[r_rd_ptr];

   always_ff @(posedge pclk_i) begin
      if (rst_i) begin
         r_vsync_d <= 1'b0;
         r_hsync_d <= 1'b0;
         r_data_d  <= '0;
      end else begin
         r_vsync_d <= bus.vsync_i;
         r_hsync_d <= bus.hsync_i;
         r_data_d  <= bus.data_i;
      end
   end

   always_ff @(posedge pclk_i) begin
      if (rst_i) begin
         r_idx       <= '0;
         r_pix       <= '0;
         r_sof_armed <= 1'b0;
         r_push      <= 1'b0;
         r_push_ent  <= '0;
         r_err       <= 1'b0;
         r_line_cnt  <= '0;
      end else begin
         r_push <= w_pix_done;
         if (w_pix_done) begin
            r_push_ent  <= {r_sof_armed, w_line_end, w_pix_next};
            r_sof_armed <= 1'b0;
         end
         if (w_frame_start) begin
            r_sof_armed <= 1'b1;
            r_line_cnt  <= '0;
         end
         if (w_active) begin
            r_pix <= w_pix_next;
            if (w_line_end || w_pix_done) begin
               r_idx <= '0;
            end else begin
               r_idx <= r_idx + 2'd1;
            end
            if (w_line_end && !w_pix_done) begin
               r_err <= 1'b1;
            end
            if (w_line_end && (r_line_cnt != c_LINE_MAX)) begin
               r_line_cnt <= r_line_cnt + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge pclk_i) begin
      if (w_wr_en) begin
         r_mem[r_wr_ptr] <= r_push_ent;
      end
   end

   // A push into a full FIFO still lands when the head is popped on the same edge.
   always_ff @(posedge pclk_i) begin
      if (rst_i) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_wr_en) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_wr_en, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
         if (r_push && !w_wr_en) begin
            r_overflow <= 1'b1;
         end
      end
   end

   always_comb begin
      bus.tvalid_o   = w_valid;
      bus.tdata_o    = w_valid ? w_head[c_PIX_W-1:0] : '0;
      bus.tuser_o    = w_valid & w_head[c_PIX_W+1];
      bus.tlast_o    = w_valid & w_head[c_PIX_W];
      bus.tkeep_o    = '1;
      bus.overflow_o = r_overflow;
      bus.err_o      = r_err;
      bus.line_cnt_o = r_line_cnt;
   end
endmodule
`default_nettype wire

// File: tb/tb_dvp_axis_pack.sv
`default_nettype none
// ============================================================================
// Module   : tb_dvp_axis_pack
// Function : Randomized self-checking bench, two instances (2 and 1 bytes per pixel) share one DVP stimulus
// Revision : 1.0  initial release
// ============================================================================
module tb_dvp_axis_pack;
   localparam int DEPTH = 16;

   typedef struct {
      logic [31:0] data;
      logic        user;
      logic        last;
   } beat_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       vsync = 1'b1;
   logic       hsync = 1'b0;
   logic [7:0] data = '0;
   logic       tready = 1'b0;
   int         tr_mode = 0;
   logic       tr_fix = 1'b0;

   beat_t      exp1[$];
   beat_t      exp2[$];
   int         f_len[$];
   logic [7:0] f_byte[$];
   bit         err_m1 = 0;
   bit         err_m2 = 0;
   bit         ovf_m = 0;
   int         n_checks = 0;
   int         n_errors = 0;

   always #5 clk = ~clk;

   dvp_axis_pack_if #(.BYTE_W(8), .BYTES_PER_PIX(2), .LINE_CNT_W(12)) bus2 ();
   dvp_axis_pack_if #(.BYTE_W(8), .BYTES_PER_PIX(1), .LINE_CNT_W(12)) bus1 ();

   assign bus2.vsync_i  = vsync;
   assign bus2.hsync_i  = hsync;
   assign bus2.data_i   = data;
   assign bus2.tready_i = tready;
   assign bus1.vsync_i  = vsync;
   assign bus1.hsync_i  = hsync;
   assign bus1.data_i   = data;
   assign bus1.tready_i = tready;

   dvp_axis_pack #(.BYTE_W(8), .BYTES_PER_PIX(2), .FIFO_DEPTH(DEPTH), .LINE_CNT_W(12)) u_dut2 (
      .pclk_i (clk),
      .rst_i  (rst),
      .bus    (bus2.master)
   );

   dvp_axis_pack #(.BYTE_W(8), .BYTES_PER_PIX(1), .FIFO_DEPTH(DEPTH), .LINE_CNT_W(12)) u_dut1 (
      .pclk_i (clk),
      .rst_i  (rst),
      .bus    (bus1.master)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Sink ready pattern: fixed, low one cycle in three, or random but never low twice in a row.
   int tr_phase = 0;
   always @(posedge clk) begin
      #1;
      case (tr_mode)
         0: tready = tr_fix;
         1: begin
            tr_phase = (tr_phase + 1) % 3;
            tready   = (tr_phase != 0);
         end
         default: tready = !tready ? 1'b1 : ($urandom_range(0, 2) != 0);
      endcase
   end

   logic        stall2 = 1'b0, stall1 = 1'b0;
   logic [15:0] hold2 = '0;
   logic [7:0]  hold1 = '0;

   always @(negedge clk) begin
      beat_t b;
      if (rst) begin
         stall2 <= 1'b0;
      end else begin
         if (stall2 && bus2.tvalid_o) chk("hold2", bus2.tdata_o, hold2);
         stall2 <= bus2.tvalid_o && !bus2.tready_i;
         hold2  <= bus2.tdata_o;
         if (bus2.tvalid_o && bus2.tready_i) begin
            if (exp2.size() == 0) begin
               chk("extra2", bus2.tdata_o, 64'hdead);
            end else begin
               b = exp2.pop_front();
               chk("data2", bus2.tdata_o, b.data);
               chk("user2", bus2.tuser_o, b.user);
               chk("last2", bus2.tlast_o, b.last);
               chk("keep2", bus2.tkeep_o, 2'b11);
            end
         end
      end
   end

   always @(negedge clk) begin
      beat_t b;
      if (rst) begin
         stall1 <= 1'b0;
      end else begin
         if (stall1 && bus1.tvalid_o) chk("hold1", bus1.tdata_o, hold1);
         stall1 <= bus1.tvalid_o && !bus1.tready_i;
         hold1  <= bus1.tdata_o;
         if (bus1.tvalid_o && bus1.tready_i) begin
            if (exp1.size() == 0) begin
               chk("extra1", bus1.tdata_o, 64'hdead);
            end else begin
               b = exp1.pop_front();
               chk("data1", bus1.tdata_o, b.data);
               chk("user1", bus1.tuser_o, b.user);
               chk("last1", bus1.tlast_o, b.last);
            end
         end
      end
   end

   // Reference: each line yields floor(len/bpp) pixels, first byte in MSBs; tlast only on a line
   // that ends on a pixel boundary; tuser on the first pixel of the frame; stalled overflow keeps first DEPTH.
   task automatic model_frame(input int bpp, input bit stalled);
      int    pos = 0;
      bit    first = 1;
      beat_t q[$];
      beat_t b;
      foreach (f_len[l]) begin
         int len = f_len[l];
         int np = len / bpp;
         if (len % bpp != 0) begin
            if (bpp == 1) err_m1 = 1; else err_m2 = 1;
         end
         for (int p = 0; p < np; p++) begin
            b.data = 0;
            for (int k = 0; k < bpp; k++) b.data = (b.data << 8) | 32'(f_byte[pos + p*bpp + k]);
            b.user = first;
            b.last = (len % bpp == 0) && (p == np - 1);
            first  = 0;
            q.push_back(b);
         end
         pos += len;
      end
      if (stalled && q.size() > DEPTH) begin
         ovf_m = 1;
         while (q.size() > DEPTH) void'(q.pop_back());
      end
      foreach (q[i]) begin
         if (bpp == 1) exp1.push_back(q[i]); else exp2.push_back(q[i]);
      end
   endtask

   task automatic send_frame(input int gap);
      int pos = 0;
      vsync = 1'b1; hsync = 1'b0;
      tick(); tick();
      vsync = 1'b0;
      tick(); tick();
      foreach (f_len[l]) begin
         for (int k = 0; k < f_len[l]; k++) begin
            hsync = 1'b1;
            data  = f_byte[pos];
            pos++;
            tick();
         end
         hsync = 1'b0;
         data  = 8'($urandom);
         repeat (gap) tick();
      end
      vsync = 1'b1;
      tick();
   endtask

   task automatic run_frame(input int gap, input bit stalled);
      model_frame(2, stalled);
      model_frame(1, stalled);
      send_frame(gap);
   endtask

   task automatic drain();
      for (int i = 0; i < 3000; i++) begin
         if (exp1.size() == 0 && exp2.size() == 0 && !bus1.tvalid_o && !bus2.tvalid_o) break;
         @(posedge clk);
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("left1", exp1.size(), 0);
      chk("left2", exp2.size(), 0);
      chk("idle1", bus1.tvalid_o, 0);
      chk("idle2", bus2.tvalid_o, 0);
   endtask

   task automatic check_status(input int lines);
      chk("lines1", bus1.line_cnt_o, lines);
      chk("lines2", bus2.line_cnt_o, lines);
      chk("err1", bus1.err_o, err_m1);
      chk("err2", bus2.err_o, err_m2);
      chk("ovf1", bus1.overflow_o, ovf_m);
      chk("ovf2", bus2.overflow_o, ovf_m);
   endtask

   task automatic load_counting_frame();
      f_len.delete(); f_byte.delete();
      f_len = '{8, 8, 8};
      for (int i = 1; i <= 24; i++) f_byte.push_back(8'(i));
   endtask

   task automatic load_random_frame(input int nl, input int lo, input int hi);
      f_len.delete(); f_byte.delete();
      for (int l = 0; l < nl; l++) begin
         int len = $urandom_range(lo, hi);
         f_len.push_back(len);
         for (int k = 0; k < len; k++) f_byte.push_back(8'($urandom));
      end
   endtask

   task automatic check_reset_state(input string tag);
      chk({tag, "_valid2"}, bus2.tvalid_o, 0);
      chk({tag, "_valid1"}, bus1.tvalid_o, 0);
      chk({tag, "_data2"}, bus2.tdata_o, 0);
      chk({tag, "_user2"}, bus2.tuser_o, 0);
      chk({tag, "_last2"}, bus2.tlast_o, 0);
      chk({tag, "_ovf2"}, bus2.overflow_o, 0);
      chk({tag, "_ovf1"}, bus1.overflow_o, 0);
      chk({tag, "_err2"}, bus2.err_o, 0);
      chk({tag, "_lines2"}, bus2.line_cnt_o, 0);
   endtask

   initial begin
      logic [7:0] a, b;
      repeat (3) tick();
      check_reset_state("rst0");
      rst = 1'b0;
      tick();

      // counting frame, sink always ready
      tr_mode = 0; tr_fix = 1'b1;
      load_counting_frame();
      run_frame(6, 0);
      drain();
      check_status(3);

      // same frame, sink stalls one cycle in three
      tr_mode = 1;
      run_frame(6, 0);
      drain();
      check_status(3);

      // odd-length line then a normal one
      tr_mode = 0; tr_fix = 1'b1;
      f_len.delete(); f_byte.delete();
      f_len = '{7, 8};
      for (int i = 0; i < 15; i++) f_byte.push_back(8'($urandom));
      run_frame(6, 0);
      drain();
      check_status(2);

      // random frames with random backpressure
      tr_mode = 2;
      for (int f = 0; f < 4; f++) begin
         load_random_frame($urandom_range(1, 4), 1, 16);
         run_frame(20, 0);
         drain();
         check_status(f_len.size());
      end

      // sink held off for a whole long line
      tr_mode = 0; tr_fix = 1'b0;
      load_random_frame(1, 40, 40);
      run_frame(4, 1);
      repeat (4) tick();
      chk("ovf_stall2", bus2.overflow_o, 1);
      chk("ovf_stall1", bus1.overflow_o, 1);
      tr_fix = 1'b1;
      drain();
      check_status(1);

      // reset with beats buffered
      tr_fix = 1'b0;
      vsync = 1'b1; tick(); tick();
      vsync = 1'b0; tick(); tick();
      for (int k = 0; k < 10; k++) begin
         hsync = 1'b1; data = 8'($urandom); tick();
      end
      hsync = 1'b0;
      repeat (4) tick();
      chk("prerst_valid2", bus2.tvalid_o, 1);
      chk("prerst_valid1", bus1.tvalid_o, 1);
      rst = 1'b1; vsync = 1'b1;
      tick();
      check_reset_state("midrst");
      rst = 1'b0;
      exp1.delete(); exp2.delete();
      err_m1 = 0; err_m2 = 0; ovf_m = 0;
      tick();
      tr_fix = 1'b1;
      load_counting_frame();
      run_frame(3, 0);
      drain();
      check_status(3);

      // latency: byte sampled at edge E shows as tvalid after E+2
      tr_fix = 1'b0;
      repeat (3) tick();
      vsync = 1'b0; tick(); tick();
      a = 8'($urandom); b = 8'($urandom);
      hsync = 1'b1; data = a;
      @(posedge clk); #1 data = b;
      @(negedge clk); chk("lat1_e0", bus1.tvalid_o, 0);
      @(posedge clk); #1 begin hsync = 1'b0; data = '0; end
      @(negedge clk); chk("lat1_e1", bus1.tvalid_o, 0);
      chk("lat2_e0", bus2.tvalid_o, 0);
      @(posedge clk);
      @(negedge clk); chk("lat1_e2", bus1.tvalid_o, 1);
      chk("lat2_e1", bus2.tvalid_o, 0);
      @(posedge clk);
      @(negedge clk); chk("lat2_e2", bus2.tvalid_o, 1);
      exp1.push_back('{data: 32'(a), user: 1'b1, last: 1'b0});
      exp1.push_back('{data: 32'(b), user: 1'b0, last: 1'b1});
      exp2.push_back('{data: {16'h0, a, b}, user: 1'b1, last: 1'b1});
      @(posedge clk); #1 vsync = 1'b1;
      tr_fix = 1'b1;
      drain();
      check_status(1);

      // back-to-back lines with a single-cycle hsync gap
      load_random_frame(3, 2, 10);
      run_frame(1, 0);
      drain();
      check_status(3);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
`default_nettype wire
